// File: rtl/dijkstra_pkg.sv
// Shared types and constants for the Dijkstra relaxation stage.
// Default sizing: 8 nodes, 3-bit index, 8-bit distances with all-ones as INFINITY.
package dijkstra_pkg;
  localparam int DEF_MAX_NODES   = 8;
  localparam int DEF_INDEX_WIDTH = 3;
  localparam int DEF_VALUE_WIDTH = 8;

  localparam logic [DEF_VALUE_WIDTH-1:0] INFINITY = '1;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SETTLE,
    WAIT_MIN,
    FETCH,
    RELAX,
    DONE
  } relax_state_t;
endpackage

// File: rtl/relax_controller_if.sv
// Bundle between the relax controller (master) and its priority queue plus
// adjacency RAM (slave).
interface relax_controller_if
  import dijkstra_pkg::*;
#(
  parameter int MAX_NODES   = DEF_MAX_NODES,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int VALUE_WIDTH = DEF_VALUE_WIDTH
);
  // min_ready is a level-valid qualifier for min_index/min_value: the master
  // consumes the pair on any WAIT_MIN cycle where it is high; there is no ready back.
  logic                   pq_reset;
  logic                   pq_set_en;
  logic [INDEX_WIDTH-1:0] pq_index;
  logic [VALUE_WIDTH-1:0] pq_write_value;
  logic [VALUE_WIDTH-1:0] pq_read_value;
  logic [INDEX_WIDTH-1:0] min_index;
  logic [VALUE_WIDTH-1:0] min_value;
  logic                   min_ready;
  logic [INDEX_WIDTH-1:0] adj_row;
  logic [INDEX_WIDTH-1:0] adj_col;
  logic [VALUE_WIDTH-1:0] adj_weight;
  logic [MAX_NODES-1:0]   visited_vector;

  modport master (
    output pq_reset, pq_set_en, pq_index, pq_write_value,
    output adj_row, adj_col, visited_vector,
    input  pq_read_value, min_index, min_value, min_ready, adj_weight
  );

  modport slave (
    input  pq_reset, pq_set_en, pq_index, pq_write_value,
    input  adj_row, adj_col, visited_vector,
    output pq_read_value, min_index, min_value, min_ready, adj_weight
  );
endinterface

// File: rtl/relax_compare.sv
// Edge relaxation test: new distance du+weight is accepted only when the edge
// exists, the sum neither overflows nor reaches INFINITY, and it beats cur_dist.
module relax_compare #(
  parameter int VALUE_WIDTH = 8
) (
  input  logic [VALUE_WIDTH-1:0] du,
  input  logic [VALUE_WIDTH-1:0] weight,
  input  logic [VALUE_WIDTH-1:0] cur_dist,
  output logic                   update,
  output logic [VALUE_WIDTH-1:0] new_dist
);
  localparam logic [VALUE_WIDTH-1:0] INF = '1;

  logic [VALUE_WIDTH:0] sum;

  always_comb begin
    sum      = {1'b0, du} + {1'b0, weight};
    new_dist = sum[VALUE_WIDTH-1:0];
    // One extra bit makes the overflow case compare above INFINITY.
    update   = (weight != INF) && (sum < {1'b0, INF}) && (sum < {1'b0, cur_dist});
  end
endmodule

// File: rtl/relax_controller.sv
// Dijkstra control stage: pops the queue minimum, marks it visited and relaxes
// every neighbour. Optional RELAX_PRED_TRACK_EN adds a predecessor vector output.
module relax_controller
  import dijkstra_pkg::*;
#(
  parameter int MAX_NODES   = DEF_MAX_NODES,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int VALUE_WIDTH = DEF_VALUE_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] source,
  relax_controller_if.master     pq,
  output logic                   busy,
  output logic                   done,
  output relax_state_t           debug_state
`ifdef RELAX_PRED_TRACK_EN
  ,
  output logic [MAX_NODES-1:0][INDEX_WIDTH-1:0] pred_vector
`endif
);
  localparam logic [VALUE_WIDTH-1:0] INF  = '1;
  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(MAX_NODES - 1);

  relax_state_t           state, state_next;
  logic [INDEX_WIDTH-1:0] u_q, v_q, src_q;
  logic [VALUE_WIDTH-1:0] du_q;
  logic [MAX_NODES-1:0]   visited_q;
  logic                   search_over;
  logic                   update;
  logic [VALUE_WIDTH-1:0] new_dist;

  relax_compare #(.VALUE_WIDTH(VALUE_WIDTH)) u_compare (
    .du       (du_q),
    .weight   (pq.adj_weight),
    .cur_dist (pq.pq_read_value),
    .update   (update),
    .new_dist (new_dist)
  );

  assign search_over = (pq.min_value == INF) || (&visited_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      u_q       <= '0;
      v_q       <= '0;
      src_q     <= '0;
      du_q      <= '0;
      visited_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE, DONE: if (start) src_q <= source;
        INIT:       visited_q <= '0;
        WAIT_MIN: begin
          if (pq.min_ready) begin
            u_q  <= pq.min_index;
            du_q <= pq.min_value;
            if (!search_over) begin
              visited_q[pq.min_index] <= 1'b1;
              v_q                     <= '0;
            end
          end
        end
        RELAX:      if (v_q != LAST) v_q <= v_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next        = state;
    pq.pq_reset       = 1'b0;
    pq.pq_set_en      = 1'b0;
    pq.pq_index       = v_q;
    pq.pq_write_value = '0;
    case (state)
      IDLE, DONE: if (start) state_next = INIT;
      INIT: begin
        pq.pq_reset = 1'b1;
        pq.pq_index = src_q;
        state_next  = SETTLE;
      end
      // The queue's minimum is stale for one cycle after any write.
      SETTLE:   state_next = WAIT_MIN;
      WAIT_MIN: if (pq.min_ready) state_next = search_over ? DONE : FETCH;
      FETCH:    state_next = RELAX;
      RELAX: begin
        if (update && !visited_q[v_q]) begin
          pq.pq_set_en      = 1'b1;
          pq.pq_write_value = new_dist;
        end
        state_next = (v_q == LAST) ? SETTLE : FETCH;
      end
      default:  state_next = IDLE;
    endcase
  end

  assign pq.adj_row        = u_q;
  assign pq.adj_col        = v_q;
  assign pq.visited_vector = visited_q;
  assign busy              = (state != IDLE) && (state != DONE);
  assign done              = (state == DONE);
  assign debug_state       = state;

`ifdef RELAX_PRED_TRACK_EN
  logic [MAX_NODES-1:0][INDEX_WIDTH-1:0] pred_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      pred_q <= '0;
    end else if (state == INIT) begin
      for (int i = 0; i < MAX_NODES; i++) pred_q[i] <= INDEX_WIDTH'(i);
    end else if (pq.pq_set_en) begin
      pred_q[v_q] <= u_q;
    end
  end

  assign pred_vector = pred_q;
`endif
endmodule

// File: tb/tb_relax_controller.sv
// Bench for relax_controller: behavioural queue/RAM environment, a Dijkstra
// reference producing the expected write sequence, directed and random graphs.
module tb_relax_controller;
  import dijkstra_pkg::*;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int VW = 8;
  localparam logic [VW-1:0] INF = INFINITY;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] source = '0;
  logic          busy, done;
  relax_state_t  debug_state;
`ifdef RELAX_PRED_TRACK_EN
  logic [N-1:0][IW-1:0] pred_vector;
`endif

  relax_controller_if #(.MAX_NODES(N), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) bus ();

  relax_controller #(.MAX_NODES(N), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .source      (source),
    .pq          (bus),
    .busy        (busy),
    .done        (done),
    .debug_state (debug_state)
`ifdef RELAX_PRED_TRACK_EN
    ,
    .pred_vector (pred_vector)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- environment: adjacency RAM and priority queue ----------------
  logic [VW-1:0] adj   [N][N];
  logic [VW-1:0] qdist [N];
  logic          ready_gate = 1'b1;
  logic          stall_mode = 1'b0;

  always @(posedge clock) begin
    bus.adj_weight <= adj[bus.adj_row][bus.adj_col];
    if (bus.pq_reset) begin
      for (int i = 0; i < N; i++) qdist[i] <= INF;
      qdist[bus.pq_index] <= '0;
    end else if (bus.pq_set_en) begin
      qdist[bus.pq_index] <= bus.pq_write_value;
    end
  end

  always_comb begin
    bus.min_index = '0;
    bus.min_value = INF;
    for (int i = 0; i < N; i++)
      if (!bus.visited_vector[i] && qdist[i] < bus.min_value) begin
        bus.min_index = IW'(i);
        bus.min_value = qdist[i];
      end
    bus.pq_read_value = qdist[bus.pq_index];
    bus.min_ready     = ready_gate;
  end

  always @(negedge clock) ready_gate = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [IW+VW-1:0] exp_q[$];
  logic [IW+VW-1:0] wr_log[$];
  logic [VW-1:0]    ref_dist [N];
  logic [N-1:0]     ref_visited;
  int               ref_pred [N];
  int               ref_rounds;
  int               cur_src = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Dijkstra over plain integers; ties go to the lowest index, as the queue does.
  task automatic ref_run(input int src);
    int d [N];
    int u, best, w;
    for (int i = 0; i < N; i++) begin
      d[i] = int'(INF);
      ref_pred[i] = i;
    end
    d[src] = 0;
    ref_visited = '0;
    ref_rounds = 0;
    exp_q.delete();
    while (1) begin
      u = -1;
      best = int'(INF);
      for (int i = 0; i < N; i++)
        if (!ref_visited[i] && d[i] < best) begin
          best = d[i];
          u = i;
        end
      if (u < 0) break;
      ref_visited[u] = 1'b1;
      ref_rounds++;
      for (int v = 0; v < N; v++) begin
        w = int'(adj[u][v]);
        if (!ref_visited[v] && w != int'(INF) && best + w < int'(INF) && best + w < d[v]) begin
          d[v] = best + w;
          ref_pred[v] = u;
          exp_q.push_back({IW'(v), VW'(best + w)});
        end
      end
    end
    for (int i = 0; i < N; i++) ref_dist[i] = VW'(d[i]);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      check("busy_done_exclusive", {31'b0, busy && done}, 32'd0);
      if (bus.pq_reset || bus.pq_set_en)
        check("strobe_exclusive", {31'b0, bus.pq_reset && bus.pq_set_en}, 32'd0);
      if (bus.pq_reset)
        check("init_index", 32'(bus.pq_index), 32'(cur_src));
      if (bus.pq_set_en) begin
        wr_log.push_back({bus.pq_index, bus.pq_write_value});
        if (exp_q.size() == 0)
          check("unexpected_write", 32'({bus.pq_index, bus.pq_write_value}), 32'hFFFF_FFFF);
        else
          check("write", 32'({bus.pq_index, bus.pq_write_value}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_graph();
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) adj[a][b] = INF;
  endtask

  task automatic add_edge(input int a, input int b, input int w);
    adj[a][b] = VW'(w);
    adj[b][a] = VW'(w);
  endtask

  task automatic random_graph();
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++)
        if (a == b || $urandom_range(0, 1) == 0) adj[a][b] = INF;
        else if ($urandom_range(0, 2) != 0)     adj[a][b] = VW'($urandom_range(1, 40));
        else                                     adj[a][b] = VW'($urandom_range(100, 254));
  endtask

  task automatic pulse_start(input int src);
    cur_src = src;
    @(negedge clock);
    source = IW'(src);
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
  endtask

  task automatic run_search(input int src, input logic stall, output int busy_cycles);
    int n;
    ref_run(src);
    stall_mode = stall;
    wr_log.delete();
    pulse_start(src);
    busy_cycles = 0;
    n = 0;
    while (!done && n < 5000) begin
      if (busy) busy_cycles++;
      @(negedge clock);
      n++;
    end
    check("done_reached", {31'b0, done}, 32'd1);
    check("busy_at_done", {31'b0, busy}, 32'd0);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    check("visited", 32'(bus.visited_vector), 32'(ref_visited));
    for (int i = 0; i < N; i++) check("final_dist", 32'(qdist[i]), 32'(ref_dist[i]));
    if (!stall) check("busy_cycles", 32'(busy_cycles), 32'(3 + ref_rounds * (2 * N + 2)));
`ifdef RELAX_PRED_TRACK_EN
    for (int i = 0; i < N; i++) check("pred", 32'(pred_vector[i]), 32'(ref_pred[i]));
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int bc, n, cnt2;
    clear_graph();
    repeat (3) @(negedge clock);
    check("rst_state", 32'(debug_state), 32'(IDLE));
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_visited", 32'(bus.visited_vector), 32'd0);
    check("rst_pq_reset", {31'b0, bus.pq_reset}, 32'd0);
    check("rst_set_en", {31'b0, bus.pq_set_en}, 32'd0);
    check("rst_index", 32'(bus.pq_index), 32'd0);
    check("rst_adj", 32'({bus.adj_row, bus.adj_col}), 32'd0);
`ifdef RELAX_PRED_TRACK_EN
    check("rst_pred", 32'(pred_vector), 32'd0);
`endif
    reset = 1'b0;

    // Chain 0-1-2
    clear_graph(); add_edge(0, 1, 3); add_edge(1, 2, 4);
    run_search(0, 1'b0, bc);
    check("chain_d1", 32'(qdist[1]), 32'd3);
    check("chain_d2", 32'(qdist[2]), 32'd7);
    check("chain_d3", 32'(qdist[3]), 32'(INF));
    check("chain_visited", 32'(bus.visited_vector), 32'b111);
    check("chain_cycles", 32'(bc), 32'(3 + 3 * 18));

    // Triangle: node 1 improved through node 2
    clear_graph(); add_edge(0, 1, 10); add_edge(0, 2, 2); add_edge(2, 1, 3);
    run_search(0, 1'b0, bc);
    check("tri_nwrites", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) begin
      check("tri_w0", 32'(wr_log[0]), 32'({3'd1, 8'd10}));
      check("tri_w1", 32'(wr_log[1]), 32'({3'd2, 8'd2}));
      check("tri_w2", 32'(wr_log[2]), 32'({3'd1, 8'd5}));
    end
    check("tri_dist", 32'({qdist[0], qdist[1], qdist[2]}), 32'({8'd0, 8'd5, 8'd2}));
`ifdef RELAX_PRED_TRACK_EN
    check("tri_pred", 32'({pred_vector[0], pred_vector[1], pred_vector[2]}), 32'({3'd0, 3'd2, 3'd0}));
`endif

    // Overflow: 254 + 5 must not reach node 2
    clear_graph(); add_edge(0, 1, 254); add_edge(1, 2, 5);
    run_search(0, 1'b0, bc);
    check("ovf_d1", 32'(qdist[1]), 32'd254);
    check("ovf_d2", 32'(qdist[2]), 32'(INF));
    cnt2 = 0;
    foreach (wr_log[i]) if (wr_log[i][IW+VW-1:VW] == IW'(2)) cnt2++;
    check("ovf_no_write_2", 32'(cnt2), 32'd0);

    // Isolated source
    clear_graph();
    run_search(3, 1'b0, bc);
    check("iso_nwrites", 32'(wr_log.size()), 32'd0);
    check("iso_visited", 32'(bus.visited_vector), 32'b0000_1000);
    check("iso_cycles", 32'(bc), 32'd21);

    // Reset during RELAX, then a clean re-run of the chain
    clear_graph(); add_edge(0, 1, 3); add_edge(1, 2, 4);
    ref_run(0);
    stall_mode = 1'b0;
    pulse_start(0);
    n = 0;
    while (debug_state != RELAX && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("reach_relax", 32'(debug_state), 32'(RELAX));
    #1 reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    check("abort_state", 32'(debug_state), 32'(IDLE));
    check("abort_set_en", {31'b0, bus.pq_set_en}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    run_search(0, 1'b0, bc);
    check("rerun_d2", 32'(qdist[2]), 32'd7);
    check("rerun_visited", 32'(bus.visited_vector), 32'b111);

    // Random graphs, random sources, random min_ready stalls
    for (int t = 0; t < 24; t++) begin
      random_graph();
      run_search($urandom_range(0, N - 1), 1'($urandom_range(0, 1)), bc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
